// File: rtl/shift_deser4_if.sv
// Serial receive link bundle: stimulus side (master) and receiver side (slave).
`default_nettype none

interface shift_deser4_if #(
  parameter int WIDTH = 4
);
  logic             Start;
  logic             SerIn;
  logic             SerValid;
  logic             Ack;
  logic             ClrOvr;
  logic [WIDTH-1:0] Q;
  logic             QValid;
  logic             Busy;
  logic             Overrun;

  modport master (
    output Start, SerIn, SerValid, Ack, ClrOvr,
    input  Q, QValid, Busy, Overrun
  );

  modport slave (
    input  Start, SerIn, SerValid, Ack, ClrOvr,
    output Q, QValid, Busy, Overrun
  );
endinterface

`default_nettype wire

// File: rtl/shift_deser4.sv
// Serial-in parallel-out receiver: Start-framed, strobe-qualified bits assembled
// into a WIDTH-bit word held behind a valid/ack handshake with sticky overrun.
`default_nettype none

module shift_deser4 #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  wire               Clk,
  input  wire               ResetB,
  shift_deser4_if.slave     bus
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    count, count_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [WIDTH-1:0] q, q_d;
  logic             qvalid, qvalid_d;
  logic             overrun, overrun_d;
  logic [WIDTH-1:0] sreg_shift;
  logic             complete;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign sreg_shift = {bus.SerIn, sreg[WIDTH-1:1]};
    end else begin : g_msb_first
      assign sreg_shift = {sreg[WIDTH-2:0], bus.SerIn};
    end
  endgenerate

  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) begin
      state   <= IDLE;
      count   <= '0;
      sreg    <= '0;
      q       <= '0;
      qvalid  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_d;
      count   <= count_d;
      sreg    <= sreg_d;
      q       <= q_d;
      qvalid  <= qvalid_d;
      overrun <= overrun_d;
    end
  end

  always_comb begin
    state_d  = state;
    count_d  = count;
    sreg_d   = sreg;
    complete = 1'b0;

    // Start outranks SerValid, so a bit arriving with a restart is dropped.
    if (bus.Start) begin
      state_d = RECV;
      count_d = '0;
      sreg_d  = '0;
    end else if (state == RECV && bus.SerValid) begin
      sreg_d = sreg_shift;
      if (count == LAST) begin
        complete = 1'b1;
        state_d  = IDLE;
      end else begin
        count_d = count + 1'b1;
      end
    end
  end

  always_comb begin
    q_d       = q;
    qvalid_d  = qvalid;
    overrun_d = overrun;

    if (bus.ClrOvr) overrun_d = 1'b0;
    if (bus.Ack)    qvalid_d  = 1'b0;

    // A new word beats a same-edge Ack; overwriting an unacked word is an overrun.
    if (complete) begin
      q_d      = sreg_shift;
      qvalid_d = 1'b1;
      if (qvalid && !bus.Ack) overrun_d = 1'b1;
    end
  end

  assign bus.Q       = q;
  assign bus.QValid  = qvalid;
  assign bus.Busy    = (state == RECV);
  assign bus.Overrun = overrun;

endmodule

`default_nettype wire
